vx_tl_lane_adapter: RTL

Parametrised bridge between the Vortex pipeline's per-lane dcache request/response interface and NUM_LANES independent TileLink-UL channels, one per SIMT lane. It generalises the fixed 4-lane combinational mapping into an N-lane adapter with three additions:
- per-lane outstanding-credit tracking;
- per-lane response holding registers that coalesce same-tag responses into one core response;
- write-ack absorption.

It sits between `VX_pipeline` dcache ports and the tile's dmem TileLink nodes.

---
 rtl/vx_tl_lane_adapter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/vx_tl_lane_adapter.sv
// vx_tl_lane_adapter: bridges per-lane dcache requests onto NUM_LANES TileLink-UL
// channels. Each lane has its own credit counter and response holding register.
// Held read responses that share a tag are merged into one core response.
// Write acks are absorbed inside the adapter.
// Optional feature: define VX_TL_ADAPTER_SIZE_EN to derive tl_a_size from the
// popcount of byteen. When it is undefined, tl_a_size is fixed at log2(WORD_SIZE).

module vx_tl_lane #(
  parameter int WORD_SIZE       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int TAG_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 8,
  localparam int LOG_W = $clog2(WORD_SIZE),
  localparam int WA    = ADDR_WIDTH - LOG_W,
  localparam int DW    = 8 * WORD_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [WORD_SIZE-1:0]  req_byteen,
  input  logic [WA-1:0]         req_addr,
  input  logic [DW-1:0]         req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [2:0]            a_opcode,
  output logic [2:0]            a_param,
  output logic [3:0]            a_size,
  output logic [TAG_WIDTH-1:0]  a_source,
  output logic [ADDR_WIDTH-1:0] a_address,
  output logic [WORD_SIZE-1:0]  a_mask,
  output logic [DW-1:0]         a_data,
  output logic                  a_corrupt,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [2:0]            d_opcode,
  input  logic [TAG_WIDTH-1:0]  d_source,
  input  logic [DW-1:0]         d_data,
  input  logic                  d_denied,
  input  logic                  pop,
  output logic                  held,
  output logic [TAG_WIDTH-1:0]  src,
  output logic [DW-1:0]         data,
  output logic                  held_nxt,
  output logic [TAG_WIDTH-1:0]  src_nxt,
  output logic                  denied_fire,
  output logic                  cnt_nz
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic                 held;
    logic [TAG_WIDTH-1:0] src;
    logic [DW-1:0]        data;
  } hold_t;

  logic [CW-1:0] cnt;
  logic          credit, a_fire, d_fire, capture;
  hold_t         hold_q, hold_d;

  assign credit    = (cnt != CW'(MAX_OUTSTANDING));
  assign a_valid   = req_valid & credit;
  assign req_ready = a_ready & credit;
  assign a_fire    = a_valid & a_ready;
  assign a_opcode  = req_rw ? ((&req_byteen) ? 3'd0 : 3'd1) : 3'd4;
  assign a_param   = 3'd0;
  assign a_source  = req_tag;
  assign a_address = ADDR_WIDTH'(req_addr) << LOG_W;
  assign a_mask    = req_byteen;
  assign a_data    = req_data;
  assign a_corrupt = 1'b0;

`ifdef VX_TL_ADAPTER_SIZE_EN
  logic [$clog2(WORD_SIZE+1)-1:0] ones;
  // Size from how many bytes are enabled; odd patterns fall back to a full word
  always_comb begin
    ones = '0;
    for (int b = 0; b < WORD_SIZE; b++) ones = ones + $bits(ones)'(req_byteen[b]);
    if (ones == $bits(ones)'(2))      a_size = 4'd1;
    else if (ones == $bits(ones)'(1)) a_size = 4'd0;
    else                              a_size = 4'(LOG_W);
  end
`else
  assign a_size = 4'(LOG_W);
`endif

  // A full holding slot frees up in the same cycle it is popped
  assign d_ready      = ~hold_q.held | pop;
  assign d_fire       = d_valid & d_ready;
  assign capture      = d_fire & (d_opcode != 3'd0);
  assign denied_fire  = d_fire & d_denied;
  assign hold_d.held  = capture | (hold_q.held & ~pop);
  assign hold_d.src   = capture ? d_source : hold_q.src;
  assign hold_d.data  = capture ? d_data : hold_q.data;
  assign held         = hold_q.held;
  assign src          = hold_q.src;
  assign data         = hold_q.data;
  assign held_nxt     = hold_d.held;
  assign src_nxt      = hold_d.src;
  assign cnt_nz       = |cnt;

  // Credit counter: an A fire adds one, a D fire removes one, and 0 is a floor
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else begin
      case ({a_fire, d_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   if (cnt != '0) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Holding register for AccessAckData (and any opcode other than AccessAck)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
endmodule

module vx_tl_lane_adapter #(
  parameter int NUM_LANES       = 4,
  parameter int WORD_SIZE       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int TAG_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 8,
  localparam int WA = ADDR_WIDTH - $clog2(WORD_SIZE),
  localparam int DW = 8 * WORD_SIZE
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_LANES-1:0]                  core_req_valid,
  input  logic [NUM_LANES-1:0]                  core_req_rw,
  input  logic [NUM_LANES-1:0][WORD_SIZE-1:0]   core_req_byteen,
  input  logic [NUM_LANES-1:0][WA-1:0]          core_req_addr,
  input  logic [NUM_LANES-1:0][DW-1:0]          core_req_data,
  input  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]   core_req_tag,
  output logic [NUM_LANES-1:0]                  core_req_ready,
  output logic                                  core_rsp_valid,
  output logic [NUM_LANES-1:0]                  core_rsp_tmask,
  output logic [NUM_LANES-1:0][DW-1:0]          core_rsp_data,
  output logic [TAG_WIDTH-1:0]                  core_rsp_tag,
  input  logic                                  core_rsp_ready,
  output logic [NUM_LANES-1:0]                  tl_a_valid,
  input  logic [NUM_LANES-1:0]                  tl_a_ready,
  output logic [NUM_LANES-1:0][2:0]             tl_a_opcode,
  output logic [NUM_LANES-1:0][2:0]             tl_a_param,
  output logic [NUM_LANES-1:0][3:0]             tl_a_size,
  output logic [NUM_LANES-1:0][TAG_WIDTH-1:0]   tl_a_source,
  output logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]  tl_a_address,
  output logic [NUM_LANES-1:0][WORD_SIZE-1:0]   tl_a_mask,
  output logic [NUM_LANES-1:0][DW-1:0]          tl_a_data,
  output logic [NUM_LANES-1:0]                  tl_a_corrupt,
  input  logic [NUM_LANES-1:0]                  tl_d_valid,
  output logic [NUM_LANES-1:0]                  tl_d_ready,
  input  logic [NUM_LANES-1:0][2:0]             tl_d_opcode,
  input  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]   tl_d_source,
  input  logic [NUM_LANES-1:0][DW-1:0]          tl_d_data,
  input  logic [NUM_LANES-1:0]                  tl_d_denied,
  output logic                                  busy,
  output logic                                  bus_err
);
  logic [NUM_LANES-1:0]                held, held_nxt, pop, denied_fire, cnt_nz;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0] src, src_nxt;
  logic [TAG_WIDTH-1:0]                rsp_tag, tag_nxt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vx_tl_lane #(
      .WORD_SIZE(WORD_SIZE), .ADDR_WIDTH(ADDR_WIDTH),
      .TAG_WIDTH(TAG_WIDTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_lane (
      .clock(clock), .reset(reset),
      .req_valid(core_req_valid[i]), .req_rw(core_req_rw[i]),
      .req_byteen(core_req_byteen[i]), .req_addr(core_req_addr[i]),
      .req_data(core_req_data[i]), .req_tag(core_req_tag[i]),
      .req_ready(core_req_ready[i]),
      .a_valid(tl_a_valid[i]), .a_ready(tl_a_ready[i]),
      .a_opcode(tl_a_opcode[i]), .a_param(tl_a_param[i]), .a_size(tl_a_size[i]),
      .a_source(tl_a_source[i]), .a_address(tl_a_address[i]),
      .a_mask(tl_a_mask[i]), .a_data(tl_a_data[i]), .a_corrupt(tl_a_corrupt[i]),
      .d_valid(tl_d_valid[i]), .d_ready(tl_d_ready[i]),
      .d_opcode(tl_d_opcode[i]), .d_source(tl_d_source[i]),
      .d_data(tl_d_data[i]), .d_denied(tl_d_denied[i]),
      .pop(pop[i]), .held(held[i]), .src(src[i]), .data(core_rsp_data[i]),
      .held_nxt(held_nxt[i]), .src_nxt(src_nxt[i]),
      .denied_fire(denied_fire[i]), .cnt_nz(cnt_nz[i])
    );
    assign core_rsp_tmask[i] = held[i] & (src[i] == rsp_tag);
  end

  assign core_rsp_valid = |held;
  assign core_rsp_tag   = rsp_tag;
  assign pop            = core_rsp_tmask & {NUM_LANES{core_rsp_valid & core_rsp_ready}};
  assign busy           = (|cnt_nz) | (|held);

  // Next tag is the source of the lowest-index lane that will be held
  always_comb begin
    tag_nxt = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (held_nxt[i]) tag_nxt = src_nxt[i];
  end

  // Tag is frozen while a response is stalled so a newly captured lower lane
  // cannot steal the pending response; it can only join it if the tag matches
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 rsp_tag <= '0;
    else if (!(core_rsp_valid && !core_rsp_ready)) rsp_tag <= tag_nxt;
  end

  // Sticky error flag for any denied D beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             bus_err <= 1'b0;
    else if (|denied_fire) bus_err <= 1'b1;
  end
endmodule
